// File: rtl/pong_pkg.sv
// Shared types and constants for the pong match sequencer: match phases,
// score width, serve-direction encoding and a small constant helper.
package pong_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SERVE,
      PLAY,
      POINT,
      OVER
   } match_state_e;

   localparam int SCORE_W = 4;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/pong_match_ctrl_if.sv
// Game-side signals around the match sequencer: frame/serve/miss inputs in,
// paddle/ball/score/game-over controls out.
interface pong_match_ctrl_if;
   import pong_pkg::*;

   logic               frame_tick;
   logic               swserve;
   logic               miss_left;
   logic               miss_right;
   logic               paddle_rst_n;
   logic               ball_run;
   logic               ball_dir;
   logic [SCORE_W-1:0] score_l;
   logic [SCORE_W-1:0] score_r;
   logic               game_over;
   logic               winner;

   // master is the sequencer itself; slave is the surrounding game logic
   modport master (
      input  frame_tick, swserve, miss_left, miss_right,
      output paddle_rst_n, ball_run, ball_dir, score_l, score_r, game_over, winner
   );

   modport slave (
      output frame_tick, swserve, miss_left, miss_right,
      input  paddle_rst_n, ball_run, ball_dir, score_l, score_r, game_over, winner
   );

endinterface

// File: rtl/pong_match_ctrl_btn_edge.sv
// btn_edge: two-flop synchroniser plus falling-edge detector for an active-low
// switch; emits a one-clk pulse three clocks after the pin goes low.
module btn_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic sw_n,
   output logic pulse_o
);

   logic sync_q1;
   logic sync_q2;
   logic prev;

   // Flops reset to the released level so a held-high switch never fires
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q1 <= 1'b1;
         sync_q2 <= 1'b1;
         prev    <= 1'b1;
         pulse_o <= 1'b0;
      end else begin
         sync_q1 <= sw_n;
         sync_q2 <= sync_q1;
         prev    <= sync_q2;
         pulse_o <= prev & ~sync_q2;
      end
   end

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: idle/serve/play/point/over phases, scores and paddle reset.
// Define PONG_AUTO_SERVE_EN to auto-serve after SERVE_FRAMES frame ticks in SERVE.
module pong_match_ctrl
   import pong_pkg::*;
#(
   parameter int WIN_SCORE    = 9,
   parameter int POINT_FRAMES = 60,
   parameter int SERVE_FRAMES = 120
) (
   input  logic              clk,
   input  logic              rst,
   pong_match_ctrl_if.master bus
);

   localparam int CNT_W = $clog2(max_int(POINT_FRAMES, SERVE_FRAMES) + 1);
   localparam logic [CNT_W-1:0]   POINT_LAST = CNT_W'(POINT_FRAMES - 1);
   localparam logic [SCORE_W-1:0] WIN_T      = SCORE_W'(WIN_SCORE);
`ifdef PONG_AUTO_SERVE_EN
   localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
`endif

   match_state_e       state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [SCORE_W-1:0] score_l, score_l_nxt;
   logic [SCORE_W-1:0] score_r, score_r_nxt;
   logic               ball_dir, ball_dir_nxt;
   logic               winner, winner_nxt;
   logic               paddle_rst_n, paddle_rst_n_nxt;
   logic               ball_run, ball_run_nxt;
   logic               game_over, game_over_nxt;
   logic               serve_evt;
   logic               cnt_en;
   logic               last_tick;

   btn_edge u_serve_edge (
      .clk     (clk),
      .rst_n   (rst),
      .sw_n    (bus.swserve),
      .pulse_o (serve_evt)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         cnt          <= '0;
         score_l      <= '0;
         score_r      <= '0;
         ball_dir     <= DIR_LEFT;
         winner       <= 1'b0;
         paddle_rst_n <= 1'b0;
         ball_run     <= 1'b0;
         game_over    <= 1'b0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         score_l      <= score_l_nxt;
         score_r      <= score_r_nxt;
         ball_dir     <= ball_dir_nxt;
         winner       <= winner_nxt;
         paddle_rst_n <= paddle_rst_n_nxt;
         ball_run     <= ball_run_nxt;
         game_over    <= game_over_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      last_tick = bus.frame_tick && (cnt == POINT_LAST);
      case (state)
         IDLE:  if (serve_evt) state_nxt = SERVE;
         SERVE: begin
            if (serve_evt) state_nxt = PLAY;
`ifdef PONG_AUTO_SERVE_EN
            else if (bus.frame_tick && (cnt == SERVE_LAST)) state_nxt = PLAY;
`endif
         end
         PLAY:  if (bus.miss_left || bus.miss_right) state_nxt = POINT;
         POINT: begin
            if (last_tick) begin
               state_nxt = ((score_l == WIN_T) || (score_r == WIN_T)) ? OVER : SERVE;
            end
         end
         OVER:  if (serve_evt) state_nxt = SERVE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output values are derived from the upcoming state so they land registered with it
   always_comb begin
      score_l_nxt      = score_l;
      score_r_nxt      = score_r;
      ball_dir_nxt     = ball_dir;
      winner_nxt       = winner;
      paddle_rst_n_nxt = (state_nxt == SERVE) || (state_nxt == PLAY);
      ball_run_nxt     = (state_nxt == PLAY);
      game_over_nxt    = (state_nxt == OVER);
`ifdef PONG_AUTO_SERVE_EN
      cnt_en = (state == POINT) || (state == SERVE);
`else
      cnt_en = (state == POINT);
`endif
      if (state_nxt != state)              cnt_nxt = '0;
      else if (cnt_en && bus.frame_tick)   cnt_nxt = cnt + 1'b1;
      else                                 cnt_nxt = cnt;

      case (state)
         IDLE, OVER: begin
            if (state_nxt == SERVE) begin
               score_l_nxt = '0;
               score_r_nxt = '0;
            end
         end
         PLAY: begin
            if (bus.miss_left && !bus.miss_right) begin
               if (score_r < WIN_T) score_r_nxt = score_r + 1'b1;
               ball_dir_nxt = DIR_LEFT;
            end else if (bus.miss_right && !bus.miss_left) begin
               if (score_l < WIN_T) score_l_nxt = score_l + 1'b1;
               ball_dir_nxt = DIR_RIGHT;
            end
         end
         POINT: begin
            if (state_nxt == OVER) winner_nxt = (score_r == WIN_T);
         end
         default: ;
      endcase
   end

   assign bus.score_l      = score_l;
   assign bus.score_r      = score_r;
   assign bus.ball_dir     = ball_dir;
   assign bus.winner       = winner;
   assign bus.paddle_rst_n = paddle_rst_n;
   assign bus.ball_run     = ball_run;
   assign bus.game_over    = game_over;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Self-checking bench for pong_match_ctrl: directed phase scenarios plus a
// randomized rally scored against a simple points-won model.
module tb_pong_match_ctrl;

   localparam logic [3:0] WIN = 4'd9;
   localparam int POINT_PAUSE = 60;

   logic clk;
   logic rst;
   int   tests_run;
   int   tests_failed;

   logic [3:0] exp_l;
   logic [3:0] exp_r;
   logic       exp_dir;

   pong_match_ctrl_if bus ();

   pong_match_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Serve press: pin low for 4 clocks (3 sync + 1 state update), then release and settle
   task automatic press_serve();
      bus.swserve = 1'b0;
      step(4);
      bus.swserve = 1'b1;
      step(3);
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) begin
         bus.frame_tick = 1'b1;
         step(1);
         bus.frame_tick = 1'b0;
         step(1);
      end
   endtask

   task automatic do_miss(input bit l, input bit r, input bit tick);
      bus.miss_left  = l;
      bus.miss_right = r;
      bus.frame_tick = tick;
      step(1);
      bus.miss_left  = 1'b0;
      bus.miss_right = 1'b0;
      bus.frame_tick = 1'b0;
   endtask

   // A point goes to the side that did not miss; a double miss is a replay
   function automatic void model_point(input bit l, input bit r);
      if (l && !r) begin
         if (exp_r < WIN) exp_r = exp_r + 4'd1;
         exp_dir = 1'b0;
      end else if (r && !l) begin
         if (exp_l < WIN) exp_l = exp_l + 4'd1;
         exp_dir = 1'b1;
      end
   endfunction

   task automatic test_reset();
      rst = 1'b0;
      step(2);
      tests_run++;
      if ({bus.paddle_rst_n, bus.ball_run, bus.ball_dir, bus.game_over, bus.winner} !== 5'b0) begin
         tests_failed++;
         $display("[TB] FAIL reset_ctrl: got %b expected 00000",
                  {bus.paddle_rst_n, bus.ball_run, bus.ball_dir, bus.game_over, bus.winner});
      end
      tests_run++;
      if ({bus.score_l, bus.score_r} !== 8'h00) begin
         tests_failed++;
         $display("[TB] FAIL reset_scores: got %h expected 00", {bus.score_l, bus.score_r});
      end
      rst = 1'b1;
      step(2);
      exp_l = 4'd0;
      exp_r = 4'd0;
      exp_dir = 1'b0;
   endtask

   task automatic test_serve_latency();
      bus.swserve = 1'b0;
      step(3);
      tests_run++;
      if (bus.paddle_rst_n !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL serve_early: paddle_rst_n got %b expected 0", bus.paddle_rst_n);
      end
      step(1);
      tests_run++;
      if ({bus.paddle_rst_n, bus.ball_run, bus.game_over} !== 3'b100) begin
         tests_failed++;
         $display("[TB] FAIL serve_latency: got %b expected 100",
                  {bus.paddle_rst_n, bus.ball_run, bus.game_over});
      end
      tests_run++;
      if ({bus.score_l, bus.score_r} !== 8'h00) begin
         tests_failed++;
         $display("[TB] FAIL serve_scores: got %h expected 00", {bus.score_l, bus.score_r});
      end
      bus.swserve = 1'b1;
      step(3);
   endtask

   task automatic test_point();
      bus.swserve = 1'b0;
      step(4);
      tests_run++;
      if (bus.ball_run !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL play_ball_run: got %b expected 1", bus.ball_run);
      end
      bus.swserve = 1'b1;
      step(3);
      do_miss(1'b0, 1'b1, 1'b0);
      model_point(1'b0, 1'b1);
      tests_run++;
      if ({bus.score_l, bus.score_r, bus.ball_dir, bus.ball_run, bus.paddle_rst_n} !==
          {exp_l, exp_r, exp_dir, 1'b0, 1'b0}) begin
         tests_failed++;
         $display("[TB] FAIL point_right_miss: got l=%0d r=%0d dir=%b run=%b pad=%b expected l=%0d r=%0d dir=%b run=0 pad=0",
                  bus.score_l, bus.score_r, bus.ball_dir, bus.ball_run, bus.paddle_rst_n, exp_l, exp_r, exp_dir);
      end
      frames(POINT_PAUSE - 1);
      tests_run++;
      if (bus.paddle_rst_n !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL point_pause_early: paddle_rst_n got %b expected 0", bus.paddle_rst_n);
      end
      frames(1);
      tests_run++;
      if ({bus.paddle_rst_n, bus.ball_run, bus.game_over} !== 3'b100) begin
         tests_failed++;
         $display("[TB] FAIL point_to_serve: got %b expected 100",
                  {bus.paddle_rst_n, bus.ball_run, bus.game_over});
      end
   endtask

   task automatic test_double_miss();
      press_serve();
      do_miss(1'b1, 1'b1, 1'b0);
      model_point(1'b1, 1'b1);
      tests_run++;
      if ({bus.score_l, bus.score_r, bus.ball_dir, bus.ball_run, bus.paddle_rst_n} !==
          {exp_l, exp_r, exp_dir, 1'b0, 1'b0}) begin
         tests_failed++;
         $display("[TB] FAIL double_miss: got l=%0d r=%0d dir=%b run=%b pad=%b expected l=%0d r=%0d dir=%b run=0 pad=0",
                  bus.score_l, bus.score_r, bus.ball_dir, bus.ball_run, bus.paddle_rst_n, exp_l, exp_r, exp_dir);
      end
      frames(POINT_PAUSE);
      tests_run++;
      if ({bus.paddle_rst_n, bus.game_over} !== 2'b10) begin
         tests_failed++;
         $display("[TB] FAIL double_miss_resume: got %b expected 10", {bus.paddle_rst_n, bus.game_over});
      end
   endtask

   task automatic test_win_right();
      for (int i = 1; i <= 9; i++) begin
         press_serve();
         do_miss(1'b1, 1'b0, 1'b0);
         model_point(1'b1, 1'b0);
         frames(POINT_PAUSE);
      end
      tests_run++;
      if ({bus.score_r, bus.game_over, bus.winner, bus.paddle_rst_n, bus.ball_run} !== {WIN, 4'b1100}) begin
         tests_failed++;
         $display("[TB] FAIL win_right: got r=%0d over=%b win=%b pad=%b run=%b expected r=9 over=1 win=1 pad=0 run=0",
                  bus.score_r, bus.game_over, bus.winner, bus.paddle_rst_n, bus.ball_run);
      end
      do_miss(1'b1, 1'b0, 1'b0);
      step(2);
      do_miss(1'b0, 1'b1, 1'b0);
      step(2);
      tests_run++;
      if ({bus.score_l, bus.score_r, bus.game_over} !== {exp_l, exp_r, 1'b1}) begin
         tests_failed++;
         $display("[TB] FAIL over_ignores_miss: got l=%0d r=%0d over=%b expected l=%0d r=%0d over=1",
                  bus.score_l, bus.score_r, bus.game_over, exp_l, exp_r);
      end
      press_serve();
      exp_l = 4'd0;
      exp_r = 4'd0;
      tests_run++;
      if ({bus.score_l, bus.score_r, bus.game_over, bus.paddle_rst_n} !== 10'b0000_0000_01) begin
         tests_failed++;
         $display("[TB] FAIL over_reserve: got l=%0d r=%0d over=%b pad=%b expected l=0 r=0 over=0 pad=1",
                  bus.score_l, bus.score_r, bus.game_over, bus.paddle_rst_n);
      end
   endtask

   task automatic test_random_rally();
      bit over;
      bit l, r;
      int kind;
      over = 1'b0;
      for (int pt = 0; pt < 80 && !over; pt++) begin
         if ($urandom_range(0, 3) == 0) begin
            do_miss($urandom_range(0, 1) == 1, 1'b1, 1'b0);
            step(1);
            tests_run++;
            if ({bus.score_l, bus.score_r, bus.ball_run} !== {exp_l, exp_r, 1'b0}) begin
               tests_failed++;
               $display("[TB] FAIL serve_ignores_miss: got l=%0d r=%0d run=%b expected l=%0d r=%0d run=0",
                        bus.score_l, bus.score_r, bus.ball_run, exp_l, exp_r);
            end
         end
         press_serve();
         if ($urandom_range(0, 4) == 0) press_serve();
         for (int k = $urandom_range(0, 5); k > 0; k--) begin
            bus.frame_tick = $urandom_range(0, 1) == 1;
            step(1);
            bus.frame_tick = 1'b0;
         end
         kind = $urandom_range(0, 5);
         l = (kind < 3) || (kind == 5);
         r = (kind >= 3);
         do_miss(l, r, $urandom_range(0, 1) == 1);
         model_point(l, r);
         tests_run++;
         if ({bus.score_l, bus.score_r, bus.ball_dir, bus.ball_run} !== {exp_l, exp_r, exp_dir, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL rally_point: got l=%0d r=%0d dir=%b run=%b expected l=%0d r=%0d dir=%b run=0",
                     bus.score_l, bus.score_r, bus.ball_dir, bus.ball_run, exp_l, exp_r, exp_dir);
         end
         frames(POINT_PAUSE - 1);
         tests_run++;
         if ({bus.paddle_rst_n, bus.game_over} !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL rally_pause: got %b expected 00", {bus.paddle_rst_n, bus.game_over});
         end
         frames(1);
         over = (exp_l == WIN) || (exp_r == WIN);
         tests_run++;
         if ({bus.game_over, bus.paddle_rst_n} !== {over, !over}) begin
            tests_failed++;
            $display("[TB] FAIL rally_after_pause: got over=%b pad=%b expected over=%b pad=%b",
                     bus.game_over, bus.paddle_rst_n, over, !over);
         end
         if (over) begin
            tests_run++;
            if (bus.winner !== (exp_r == WIN)) begin
               tests_failed++;
               $display("[TB] FAIL rally_winner: got %b expected %b", bus.winner, (exp_r == WIN));
            end
         end
      end
      if (over) begin
         press_serve();
         exp_l = 4'd0;
         exp_r = 4'd0;
      end
   endtask

   task automatic test_auto_serve();
`ifdef PONG_AUTO_SERVE_EN
      frames(119);
      tests_run++;
      if (bus.ball_run !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL auto_serve_early: ball_run got %b expected 0", bus.ball_run);
      end
      frames(1);
      tests_run++;
      if (bus.ball_run !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL auto_serve: ball_run got %b expected 1", bus.ball_run);
      end
`else
      frames(500);
      tests_run++;
      if ({bus.ball_run, bus.paddle_rst_n} !== 2'b01) begin
         tests_failed++;
         $display("[TB] FAIL no_auto_serve: got run=%b pad=%b expected run=0 pad=1",
                  bus.ball_run, bus.paddle_rst_n);
      end
`endif
   endtask

   task automatic test_async_reset();
      press_serve();
      do_miss(1'b0, 1'b1, 1'b0);
      model_point(1'b0, 1'b1);
      frames(POINT_PAUSE);
      press_serve();
      tests_run++;
      if ({bus.ball_run, bus.score_l} !== {1'b1, exp_l}) begin
         tests_failed++;
         $display("[TB] FAIL pre_reset_play: got run=%b l=%0d expected run=1 l=%0d",
                  bus.ball_run, bus.score_l, exp_l);
      end
      #2;
      rst = 1'b0;
      #1;
      tests_run++;
      if ({bus.paddle_rst_n, bus.ball_run, bus.ball_dir, bus.game_over, bus.winner,
           bus.score_l, bus.score_r} !== 13'b0) begin
         tests_failed++;
         $display("[TB] FAIL async_reset: got pad=%b run=%b dir=%b over=%b win=%b l=%0d r=%0d expected all 0",
                  bus.paddle_rst_n, bus.ball_run, bus.ball_dir, bus.game_over, bus.winner,
                  bus.score_l, bus.score_r);
      end
      step(2);
      rst = 1'b1;
      exp_l = 4'd0;
      exp_r = 4'd0;
      do_miss(1'b1, 1'b0, 1'b0);
      frames(2);
      tests_run++;
      if ({bus.paddle_rst_n, bus.score_r} !== 5'b0) begin
         tests_failed++;
         $display("[TB] FAIL idle_after_reset: got pad=%b r=%0d expected pad=0 r=0",
                  bus.paddle_rst_n, bus.score_r);
      end
   endtask

   initial begin
      tests_run      = 0;
      tests_failed   = 0;
      rst            = 1'b0;
      bus.frame_tick = 1'b0;
      bus.swserve    = 1'b1;
      bus.miss_left  = 1'b0;
      bus.miss_right = 1'b0;
      test_reset();
      test_serve_latency();
      test_point();
      test_double_miss();
      test_win_right();
      test_random_rally();
      test_auto_serve();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
